// File: rtl/pc_sequencer_pkg.sv
// Shared opcode constants, PC source encodings and FSM state encoding
// for the multicycle next-PC sequencer.
package pc_sequencer_pkg;

  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JR   = 4'hB;
  localparam logic [3:0] OP_BEQZ = 4'hC;
  localparam logic [3:0] OP_BLTZ = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_CAT = 2'd1;
  localparam logic [1:0] SEL_INC = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_UPDATE,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_SEQ,
    K_JMP,
    K_JR,
    K_BEQZ,
    K_BLTZ,
    K_HALT
  } kind_t;

  function automatic kind_t classify(input logic [3:0] op);
    case (op)
      OP_JMP:  return K_JMP;
      OP_JR:   return K_JR;
      OP_BEQZ: return K_BEQZ;
      OP_BLTZ: return K_BLTZ;
      OP_HALT: return K_HALT;
      default: return K_SEQ;
    endcase
  endfunction

  // Select known before the ALU flags arrive; conditional branches resolve in EXEC.
  function automatic logic [1:0] early_sel(input kind_t k);
    case (k)
      K_JMP:   return SEL_CAT;
      K_JR:    return SEL_ALU;
      default: return SEL_INC;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_mux.sv
// Three-input PC source select; the unused encoding falls back to increment.
module pc_sequencer_mux
  import pc_sequencer_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [15:0] alu,
  input  logic [15:0] cat,
  input  logic [15:0] inc,
  output logic [15:0] y
);

  always_comb begin
    case (sel)
      SEL_ALU: y = alu;
      SEL_CAT: y = cat;
      default: y = inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle next-PC controller: owns the PC, the fetch handshake and the
// control-flow decode, sequencing each instruction FETCH/DECODE/EXEC/UPDATE.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_FETCH  | FetchReq high, wait for FetchAck (bounded by FETCH_TIMEOUT)
//   ST_DECODE | classify Opcode, preload the unconditional select
//   ST_EXEC   | capture ALU result/flags, resolve the final select
//   ST_UPDATE | PCWrite strobe, PC <= selected source
//   ST_HALT   | stopped by HALT opcode or fetch fault; exit only by Reset
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int unsigned FETCH_TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        FetchAck,
  input  logic [3:0]  Opcode,
  input  logic [11:0] Imm12,
  input  logic [15:0] ALUResult,
  input  logic        ALUZero,
  input  logic        ALUNeg,
  output logic [15:0] PC,
  output logic        FetchReq,
  output logic        IRWrite,
  output logic [1:0]  PCMuxSel,
  output logic        PCWrite,
  output logic        BranchTaken,
  output logic        Halted,
  output logic        FetchFault
);

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      state, state_nxt;
  kind_t       kind;
  logic [7:0]  wait_cnt;
  logic [15:0] pc_q, alu_q, pc_nxt;
  logic [1:0]  sel_q, sel_exec;
  logic        taken_q, fault_q, timeout_hit;

  assign timeout_hit = (wait_cnt == TMO_LAST);

  always_comb begin
    sel_exec = SEL_INC;
    case (kind)
      K_JMP:   sel_exec = SEL_CAT;
      K_JR:    sel_exec = SEL_ALU;
      K_BEQZ:  if (ALUZero) sel_exec = SEL_ALU;
      K_BLTZ:  if (ALUNeg) sel_exec = SEL_ALU;
      default: sel_exec = SEL_INC;
    endcase
  end

  // IRWrite follows FetchAck so the IR captures on the edge the memory data is valid.
  // Reset masks the FETCH strobes so nothing is requested while held in reset.
  always_comb begin
    state_nxt = state;
    FetchReq  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    Halted    = 1'b0;
    case (state)
      ST_FETCH: begin
        FetchReq = ~Reset;
        IRWrite  = FetchAck & ~Reset;
        if (FetchAck)         state_nxt = ST_DECODE;
        else if (timeout_hit) state_nxt = ST_HALT;
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = (kind == K_HALT) ? ST_HALT : ST_UPDATE;
      ST_UPDATE: begin
        PCWrite   = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_HALT:   Halted = 1'b1;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_q     <= RESET_PC;
      sel_q    <= SEL_INC;
      wait_cnt <= 8'd0;
      kind     <= K_SEQ;
      alu_q    <= 16'd0;
      taken_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (FetchAck) begin
            wait_cnt <= 8'd0;
          end else if (timeout_hit) begin
            wait_cnt <= 8'd0;
            fault_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DECODE: begin
          kind  <= classify(Opcode);
          sel_q <= early_sel(classify(Opcode));
        end
        ST_EXEC: begin
          if (kind != K_HALT) begin
            alu_q   <= ALUResult;
            sel_q   <= sel_exec;
            taken_q <= (sel_exec != SEL_INC);
          end
        end
        ST_UPDATE: begin
          pc_q  <= pc_nxt;
          sel_q <= SEL_INC;
        end
        default: ;
      endcase
    end
  end

  pc_sequencer_mux u_mux (
    .sel (sel_q),
    .alu (alu_q),
    .cat ({pc_q[15:12], Imm12}),
    .inc (pc_q + 16'd1),
    .y   (pc_nxt)
  );

  assign PC          = pc_q;
  assign PCMuxSel    = sel_q;
  assign BranchTaken = taken_q;
  assign FetchFault  = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed and randomized instructions
// compared against an instruction-level next-PC model.
module tb_pc_sequencer;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int          TMO    = 8;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        FetchAck = 1'b0;
  logic [3:0]  Opcode = 4'h0;
  logic [11:0] Imm12 = 12'h000;
  logic [15:0] ALUResult = 16'h0000;
  logic        ALUZero = 1'b0;
  logic        ALUNeg = 1'b0;
  logic [15:0] PC;
  logic        FetchReq, IRWrite, PCWrite, BranchTaken, Halted, FetchFault;
  logic [1:0]  PCMuxSel;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_pc;
  logic        m_taken;
  logic        m_fault;

  always #5 CLK = ~CLK;

  pc_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TMO)) dut (
    .CLK(CLK), .Reset(Reset), .FetchAck(FetchAck), .Opcode(Opcode), .Imm12(Imm12),
    .ALUResult(ALUResult), .ALUZero(ALUZero), .ALUNeg(ALUNeg), .PC(PC),
    .FetchReq(FetchReq), .IRWrite(IRWrite), .PCMuxSel(PCMuxSel), .PCWrite(PCWrite),
    .BranchTaken(BranchTaken), .Halted(Halted), .FetchFault(FetchFault)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] exp);
    chk(tag, {14'd0, PCMuxSel}, {14'd0, exp});
  endtask

  // Instruction-level reference: where the PC goes next and which source feeds it.
  function automatic void model_next(input logic [15:0] pc, input logic [3:0] op,
                                     input logic [11:0] imm, input logic [15:0] alu,
                                     input logic z, input logic n,
                                     output logic [15:0] npc, output logic [1:0] sel);
    if (op == 4'hA) begin
      npc = {pc[15:12], imm};
      sel = 2'd1;
    end else if (op == 4'hB || (op == 4'hC && z) || (op == 4'hD && n)) begin
      npc = alu;
      sel = 2'd0;
    end else begin
      npc = pc + 16'd1;
      sel = 2'd2;
    end
  endfunction

  task automatic noise();
    ALUResult = 16'($urandom);
    ALUZero   = 1'($urandom);
    ALUNeg    = 1'($urandom);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    chk("rst_pc", PC, RST_PC);
    chk1("rst_fetchreq", FetchReq, 1'b0);
    chk1("rst_irwrite", IRWrite, 1'b0);
    chk1("rst_pcwrite", PCWrite, 1'b0);
    chk1("rst_taken", BranchTaken, 1'b0);
    chk1("rst_halted", Halted, 1'b0);
    chk1("rst_fault", FetchFault, 1'b0);
    chk_sel("rst_sel", 2'd2);
    repeat (2) @(posedge CLK);
    #1;
    Reset    = 1'b0;
    FetchAck = 1'b0;
    m_pc     = RST_PC;
    m_taken  = 1'b0;
    m_fault  = 1'b0;
  endtask

  task automatic fetch_phase(input int stalls);
    for (int i = 0; i < stalls; i++) begin
      @(negedge CLK);
      FetchAck = 1'b0;
      Opcode   = 4'($urandom);
      noise();
      #1;
      chk1("stall_fetchreq", FetchReq, 1'b1);
      chk1("stall_irwrite", IRWrite, 1'b0);
      chk("stall_pc", PC, m_pc);
      chk1("stall_pcwrite", PCWrite, 1'b0);
      chk1("stall_taken", BranchTaken, m_taken);
      chk1("stall_fault", FetchFault, m_fault);
      chk1("stall_halted", Halted, 1'b0);
      chk_sel("stall_sel", 2'd2);
    end
    @(negedge CLK);
    FetchAck = 1'b1;
    noise();
    #1;
    chk1("fetch_fetchreq", FetchReq, 1'b1);
    chk1("fetch_irwrite", IRWrite, 1'b1);
    chk("fetch_pc", PC, m_pc);
    chk1("fetch_taken", BranchTaken, m_taken);
    chk1("fetch_fault", FetchFault, m_fault);
  endtask

  task automatic decode_phase(input logic [3:0] op, input logic [11:0] imm);
    @(negedge CLK);
    FetchAck = 1'($urandom);
    Opcode   = op;
    Imm12    = imm;
    noise();
    #1;
    chk1("dec_fetchreq", FetchReq, 1'b0);
    chk1("dec_irwrite", IRWrite, 1'b0);
    chk1("dec_pcwrite", PCWrite, 1'b0);
    chk_sel("dec_sel", 2'd2);
    chk("dec_pc", PC, m_pc);
  endtask

  task automatic exec_phase(input logic [3:0] op, input logic [15:0] alu,
                            input logic z, input logic n);
    @(negedge CLK);
    FetchAck  = 1'($urandom);
    ALUResult = alu;
    ALUZero   = z;
    ALUNeg    = n;
    #1;
    chk1("exec_fetchreq", FetchReq, 1'b0);
    chk1("exec_pcwrite", PCWrite, 1'b0);
    chk1("exec_taken", BranchTaken, m_taken);
    chk("exec_pc", PC, m_pc);
    if (op == 4'hA) chk_sel("exec_sel_jmp", 2'd1);
    else if (op == 4'hB) chk_sel("exec_sel_jr", 2'd0);
  endtask

  task automatic update_phase(input logic [1:0] sel, input logic taken);
    @(negedge CLK);
    FetchAck = 1'($urandom);
    noise();
    #1;
    chk1("upd_pcwrite", PCWrite, 1'b1);
    chk1("upd_fetchreq", FetchReq, 1'b0);
    chk_sel("upd_sel", sel);
    chk1("upd_taken", BranchTaken, taken);
    chk("upd_pc", PC, m_pc);
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [11:0] imm, input logic [15:0] alu,
                          input logic z, input logic n, input int stalls);
    logic [15:0] npc;
    logic [1:0]  sel;
    model_next(m_pc, op, imm, alu, z, n, npc, sel);
    fetch_phase(stalls);
    decode_phase(op, imm);
    exec_phase(op, alu, z, n);
    update_phase(sel, sel != 2'd2);
    m_pc    = npc;
    m_taken = (sel != 2'd2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset();

    // Reset mid-EXEC with PC at 0x0042
    do_instr(4'hB, 12'h000, 16'h0042, 1'b0, 1'b0, 0);
    fetch_phase(0);
    decode_phase(4'h1, 12'h000);
    exec_phase(4'h1, 16'h1234, 1'b1, 1'b1);
    chk("pre_reset_pc", PC, 16'h0042);
    do_reset();

    // Four sequential instructions, zero-wait memory
    for (int i = 0; i < 4; i++) do_instr(4'h1, 12'($urandom), 16'($urandom), 1'b1, 1'b1, 0);

    // JMP from 0x3005
    do_instr(4'hB, 12'h000, 16'h3005, 1'b0, 1'b0, 0);
    do_instr(4'hA, 12'h0AB, 16'h5555, 1'b1, 1'b1, 0);

    // Conditional branches, taken and untaken
    do_instr(4'hC, 12'h000, 16'h0120, 1'b1, 1'b0, 0);
    do_instr(4'hB, 12'h000, 16'h0010, 1'b0, 1'b0, 0);
    do_instr(4'hC, 12'h000, 16'h0120, 1'b0, 1'b1, 0);
    do_instr(4'hD, 12'h000, 16'h0777, 1'b0, 1'b1, 0);
    do_instr(4'hD, 12'h000, 16'h0900, 1'b1, 1'b0, 0);
    do_instr(4'hB, 12'h000, 16'h4ABC, 1'b1, 1'b0, 0);

    // Increment wraps at the top of the address space
    do_instr(4'hB, 12'h000, 16'hFFFF, 1'b0, 1'b0, 0);
    do_instr(4'h1, 12'h000, 16'h0000, 1'b0, 1'b0, 0);

    // Fetch stalls: three waits, then ack on the final count
    do_instr(4'h2, 12'h000, 16'h0000, 1'b0, 1'b0, 3);
    do_instr(4'h3, 12'h000, 16'h0000, 1'b0, 1'b0, TMO - 1);

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      do_instr(4'($urandom_range(0, 14)), 12'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Fetch timeout: no ack for TMO cycles
    for (int i = 0; i < TMO; i++) begin
      @(negedge CLK);
      FetchAck = 1'b0;
      noise();
      #1;
      chk1("tmo_fetchreq", FetchReq, 1'b1);
      chk1("tmo_halted_early", Halted, 1'b0);
      chk1("tmo_fault_early", FetchFault, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      FetchAck = 1'($urandom);
      #1;
      chk1("tmo_fault", FetchFault, 1'b1);
      chk1("tmo_halted", Halted, 1'b1);
      chk1("tmo_fetchreq_off", FetchReq, 1'b0);
      chk("tmo_pc", PC, m_pc);
    end
    do_reset();

    // HALT opcode at 0x0007
    for (int i = 0; i < 7; i++) do_instr(4'h0, 12'h000, 16'($urandom), 1'b1, 1'b1, 0);
    fetch_phase(0);
    decode_phase(4'hF, 12'h123);
    exec_phase(4'hF, 16'h0BAD, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      FetchAck = 1'($urandom);
      noise();
      #1;
      chk1("halt_halted", Halted, 1'b1);
      chk1("halt_fetchreq", FetchReq, 1'b0);
      chk1("halt_irwrite", IRWrite, 1'b0);
      chk1("halt_pcwrite", PCWrite, 1'b0);
      chk("halt_pc", PC, 16'h0007);
      chk_sel("halt_sel", 2'd2);
      chk1("halt_fault", FetchFault, 1'b0);
    end
    do_reset();
    do_instr(4'h1, 12'h000, 16'h0000, 1'b0, 1'b0, 0);
    fetch_phase(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
